// File: rtl/if_axi_rd_bridge_pkg.sv
// Shared encodings for the instruction-fetch to AXI4 read bridge: FSM states,
// AXI size/burst codes, response codes and core-side fetch sizes.
package if_axi_rd_bridge_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_AR    = 3'd1,
      S_R     = 3'd2,
      S_DONE  = 3'd3,
      S_DRAIN = 3'd4
   } state_e;

   localparam logic [2:0] AXI_SIZE_1 = 3'b000;
   localparam logic [2:0] AXI_SIZE_2 = 3'b001;
   localparam logic [2:0] AXI_SIZE_4 = 3'b010;
   localparam logic [2:0] AXI_SIZE_8 = 3'b011;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam logic [1:0] IF_SIZE_B = 2'b00;
   localparam logic [1:0] IF_SIZE_H = 2'b01;
   localparam logic [1:0] IF_SIZE_W = 2'b10;
   localparam logic [1:0] IF_SIZE_D = 2'b11;

   function automatic logic [2:0] axi_size_of(input logic [1:0] if_size);
      case (if_size)
         IF_SIZE_B: axi_size_of = AXI_SIZE_1;
         IF_SIZE_H: axi_size_of = AXI_SIZE_2;
         IF_SIZE_W: axi_size_of = AXI_SIZE_4;
         default:   axi_size_of = AXI_SIZE_8;
      endcase
   endfunction

endpackage

// File: rtl/if_rdata_align.sv
// Right-justifies the addressed lanes of one 64-bit beat, zeroes the unused upper
// bits, and flags accesses whose bytes would run past the 8-byte beat.
module if_rdata_align
   import if_axi_rd_bridge_pkg::*;
(
   input  logic [63:0] i_data,
   input  logic [2:0]  i_offset,
   input  logic [1:0]  i_size,
   output logic [63:0] o_data,
   output logic        o_misalign
);

   logic [63:0] w_shifted;
   logic [3:0]  w_end;

   always_comb begin
      w_shifted = i_data >> {i_offset, 3'b000};
      case (i_size)
         IF_SIZE_B: o_data = {56'd0, w_shifted[7:0]};
         IF_SIZE_H: o_data = {48'd0, w_shifted[15:0]};
         IF_SIZE_W: o_data = {32'd0, w_shifted[31:0]};
         default:   o_data = w_shifted;
      endcase
      // One past the last byte touched; beyond 8 means the access straddles beats.
      w_end      = {1'b0, i_offset} + (4'd1 << i_size);
      o_misalign = (w_end > 4'd8);
   end

endmodule

// File: rtl/if_axi_rd_bridge.sv
// Turns each instruction-fetch request into one single-beat AXI4 read.
// Optional watchdog/drain: define IF_AXI_RD_BRIDGE_TIMEOUT_EN.
module if_axi_rd_bridge
   import if_axi_rd_bridge_pkg::*;
#(
   parameter int AXI_ID = 0,
   parameter int ID_W   = 4
`ifdef IF_AXI_RD_BRIDGE_TIMEOUT_EN
   , parameter int TIMEOUT_CYCLES = 1024
`endif
)(
   input  logic            clock,
   input  logic            reset,
   input  logic            if_valid,
   output logic            if_ready,
   input  logic [63:0]     if_addr,
   input  logic [1:0]      if_size,
   output logic [63:0]     if_data_read,
   output logic [1:0]      if_resp,
   output logic            ar_valid,
   input  logic            ar_ready,
   output logic [63:0]     ar_addr,
   output logic [ID_W-1:0] ar_id,
   output logic [7:0]      ar_len,
   output logic [2:0]      ar_size,
   output logic [1:0]      ar_burst,
   input  logic            r_valid,
   output logic            r_ready,
   input  logic [63:0]     r_data,
   input  logic [1:0]      r_resp,
   input  logic            r_last,
   input  logic [ID_W-1:0] r_id,
   output logic [2:0]      dbg_state
);

   // Handshakes: a transfer happens on a rising clock edge where valid and ready
   // are both high; ar_valid holds with stable payload until accepted, and
   // if_ready is a single-cycle completion strobe while if_valid is held.

   state_e      r_state;
   logic [2:0]  r_addr_lo;
   logic [1:0]  r_size;
   logic [63:0] w_aligned;
   logic        w_misalign;
   logic        w_beat_ok;

`ifdef IF_AXI_RD_BRIDGE_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
   logic [CNT_W-1:0] r_cnt;
   logic             r_drain;
   logic             w_timeout;
   assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

   assign ar_id     = ID_W'(AXI_ID);
   assign ar_len    = 8'd0;
   assign ar_burst  = AXI_BURST_INCR;
   assign dbg_state = r_state;
   assign w_beat_ok = r_valid && r_last && (r_id == ID_W'(AXI_ID));

   if_rdata_align u_align (
      .i_data     (r_data),
      .i_offset   (r_addr_lo),
      .i_size     (r_size),
      .o_data     (w_aligned),
      .o_misalign (w_misalign)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_addr_lo    <= 3'd0;
         r_size       <= 2'd0;
         if_ready     <= 1'b0;
         if_data_read <= 64'd0;
         if_resp      <= RESP_OKAY;
         ar_valid     <= 1'b0;
         ar_addr      <= 64'd0;
         ar_size      <= 3'd0;
         r_ready      <= 1'b0;
`ifdef IF_AXI_RD_BRIDGE_TIMEOUT_EN
         r_cnt        <= '0;
         r_drain      <= 1'b0;
`endif
      end else begin
         if_ready <= 1'b0;
`ifdef IF_AXI_RD_BRIDGE_TIMEOUT_EN
         if (r_state == S_AR || r_state == S_R) r_cnt <= r_cnt + 1'b1;
`endif
         case (r_state)
            S_IDLE: if (if_valid) begin
               r_addr_lo <= if_addr[2:0];
               r_size    <= if_size;
               ar_addr   <= {if_addr[63:3], 3'b000};
               ar_size   <= axi_size_of(if_size);
               ar_valid  <= 1'b1;
               r_state   <= S_AR;
`ifdef IF_AXI_RD_BRIDGE_TIMEOUT_EN
               r_cnt     <= '0;
`endif
            end
            S_AR: begin
               if (ar_ready) begin
                  ar_valid <= 1'b0;
                  r_ready  <= 1'b1;
                  r_state  <= S_R;
               end
`ifdef IF_AXI_RD_BRIDGE_TIMEOUT_EN
               else if (w_timeout) begin
                  // Abandoning an unaccepted address is a debug-only escape hatch.
                  ar_valid     <= 1'b0;
                  if_data_read <= 64'd0;
                  if_resp      <= RESP_DECERR;
                  if_ready     <= 1'b1;
                  r_state      <= S_DONE;
               end
`endif
            end
            S_R: begin
               if (w_beat_ok) begin
                  r_ready      <= 1'b0;
                  if_data_read <= w_aligned;
                  if_resp      <= w_misalign ? RESP_SLVERR : r_resp;
                  if_ready     <= 1'b1;
                  r_state      <= S_DONE;
               end
`ifdef IF_AXI_RD_BRIDGE_TIMEOUT_EN
               else if (w_timeout) begin
                  r_ready      <= 1'b0;
                  r_drain      <= 1'b1;
                  if_data_read <= 64'd0;
                  if_resp      <= RESP_DECERR;
                  if_ready     <= 1'b1;
                  r_state      <= S_DONE;
               end
`endif
            end
            S_DONE: begin
`ifdef IF_AXI_RD_BRIDGE_TIMEOUT_EN
               // The slave still owes a beat after an R-phase timeout; swallow it.
               r_ready <= r_drain;
               r_drain <= 1'b0;
               r_state <= r_drain ? S_DRAIN : S_IDLE;
`else
               r_state <= S_IDLE;
`endif
            end
`ifdef IF_AXI_RD_BRIDGE_TIMEOUT_EN
            S_DRAIN: if (r_valid && r_last) begin
               r_ready <= 1'b0;
               r_state <= S_IDLE;
            end
`endif
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_if_axi_rd_bridge.sv
// Directed bench for if_axi_rd_bridge; define IF_AXI_RD_BRIDGE_TIMEOUT_EN to also
// exercise the watchdog/drain path with a 16-cycle limit.
module tb_if_axi_rd_bridge;
   import if_axi_rd_bridge_pkg::*;

   localparam int ID_W   = 4;
   localparam int AXI_ID = 0;

   logic            clock = 1'b0;
   logic            reset = 1'b1;
   logic            if_valid = 1'b0;
   logic            if_ready;
   logic [63:0]     if_addr = '0;
   logic [1:0]      if_size = '0;
   logic [63:0]     if_data_read;
   logic [1:0]      if_resp;
   logic            ar_valid;
   logic            ar_ready = 1'b0;
   logic [63:0]     ar_addr;
   logic [ID_W-1:0] ar_id;
   logic [7:0]      ar_len;
   logic [2:0]      ar_size;
   logic [1:0]      ar_burst;
   logic            r_valid = 1'b0;
   logic            r_ready;
   logic [63:0]     r_data = '0;
   logic [1:0]      r_resp = '0;
   logic            r_last = 1'b0;
   logic [ID_W-1:0] r_id = '0;
   logic [2:0]      dbg_state;

   int n_checks = 0;
   int n_fail   = 0;

   // Observations returned by the driver for the scenario tasks to judge.
   logic [63:0] got_data;
   logic [1:0]  got_resp;
   logic [63:0] got_ar_addr;
   logic [2:0]  got_ar_size;
   int lat, pulses, ar_hs, r_hs;
   bit unstable, overlap, tmo, extra_busy;

   always #5 clock = ~clock;

`ifdef IF_AXI_RD_BRIDGE_TIMEOUT_EN
   if_axi_rd_bridge #(.AXI_ID(AXI_ID), .ID_W(ID_W), .TIMEOUT_CYCLES(16)) dut (
`else
   if_axi_rd_bridge #(.AXI_ID(AXI_ID), .ID_W(ID_W)) dut (
`endif
      .clock(clock), .reset(reset),
      .if_valid(if_valid), .if_ready(if_ready), .if_addr(if_addr), .if_size(if_size),
      .if_data_read(if_data_read), .if_resp(if_resp),
      .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_id(ar_id),
      .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst),
      .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp),
      .r_last(r_last), .r_id(r_id), .dbg_state(dbg_state)
   );

   // Core + AXI slave driver: all inputs change and all outputs are sampled on negedges.
   task automatic run_fetch(input logic [63:0] addr, input logic [1:0] size,
                            input logic [63:0] rdata, input logic [1:0] rresp,
                            input int ar_wait, input int r_wait, input int bad_beats,
                            input bit keep);
      int ar_seen = 0, r_seen = 0, bad_left = bad_beats;
      bit done = 0, have_ar = 0;
      got_data = '0; got_resp = '0; got_ar_addr = '0; got_ar_size = '0;
      lat = 0; pulses = 0; ar_hs = 0; r_hs = 0;
      unstable = 0; overlap = 0; tmo = 0; extra_busy = 0;
      if_valid = 1'b1; if_addr = addr; if_size = size;
      for (int cyc = 1; cyc <= 100 && !done; cyc++) begin
         @(posedge clock); @(negedge clock);
         if (cyc == 2) begin if_addr = ~addr; if_size = ~size; end
         ar_ready = 1'b0; r_valid = 1'b0; r_last = 1'b0;
         if (ar_valid && r_ready) overlap = 1;
         if (ar_valid) begin
            if (!have_ar) begin got_ar_addr = ar_addr; got_ar_size = ar_size; have_ar = 1; end
            else if (ar_addr !== got_ar_addr || ar_size !== got_ar_size) unstable = 1;
            ar_seen++;
            if (ar_seen > ar_wait) begin ar_ready = 1'b1; ar_hs++; end
         end
         if (r_ready) begin
            r_seen++;
            if (r_seen > r_wait) begin
               r_valid = 1'b1; r_last = 1'b1;
               if (bad_left > 0) begin
                  r_id = 4'h5; r_data = ~rdata; r_resp = 2'b10; bad_left--;
               end else begin
                  r_id = ID_W'(AXI_ID); r_data = rdata; r_resp = rresp; r_hs++;
               end
            end
         end
         if (if_ready) begin
            pulses++; got_data = if_data_read; got_resp = if_resp; lat = cyc; done = 1;
            if (!keep) if_valid = 1'b0;
         end
      end
      if (!done) begin tmo = 1; if_valid = 1'b0; end
      if (!keep) begin
         for (int k = 0; k < 2; k++) begin
            @(posedge clock); @(negedge clock);
            ar_ready = 1'b0; r_valid = 1'b0; r_last = 1'b0;
            if (if_ready) pulses++;
            if (ar_valid || r_ready) extra_busy = 1;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clock);
      @(negedge clock);
      n_checks++; if ({if_ready, ar_valid, r_ready} !== 3'b000) begin n_fail++;
         $display("FAIL reset_hs got=%b exp=000", {if_ready, ar_valid, r_ready}); end
      n_checks++; if (if_data_read !== 64'd0 || if_resp !== 2'b00) begin n_fail++;
         $display("FAIL reset_data got=%h/%b exp=0/00", if_data_read, if_resp); end
      n_checks++; if (ar_addr !== 64'd0 || dbg_state !== 3'd0) begin n_fail++;
         $display("FAIL reset_addr_state got=%h/%0d exp=0/0", ar_addr, dbg_state); end
      n_checks++; if (ar_len !== 8'd0 || ar_burst !== 2'b01 || ar_id !== 4'd0) begin n_fail++;
         $display("FAIL ar_consts got=%h/%b/%h exp=00/01/0", ar_len, ar_burst, ar_id); end
      reset = 1'b0;
   endtask

   task automatic test_basic();
      run_fetch(64'h8000_0004, 2'b10, 64'h1122_3344_5566_7788, 2'b00, 0, 0, 0, 0);
      n_checks++; if (tmo !== 0 || lat !== 3) begin n_fail++;
         $display("FAIL basic_latency got=%0d tmo=%0d exp=3", lat, tmo); end
      n_checks++; if (got_ar_addr !== 64'h8000_0000 || got_ar_size !== 3'b010) begin n_fail++;
         $display("FAIL basic_ar got=%h/%b exp=80000000/010", got_ar_addr, got_ar_size); end
      n_checks++; if (got_data !== 64'h0000_0000_1122_3344 || got_resp !== 2'b00) begin n_fail++;
         $display("FAIL basic_data got=%h/%b exp=11223344/00", got_data, got_resp); end
      n_checks++; if (pulses !== 1 || extra_busy !== 0) begin n_fail++;
         $display("FAIL basic_pulse got=%0d busy=%0d exp=1/0", pulses, extra_busy); end
      n_checks++; if (if_data_read !== 64'h0000_0000_1122_3344) begin n_fail++;
         $display("FAIL basic_hold got=%h exp=11223344", if_data_read); end
   endtask

   task automatic test_waits();
      run_fetch(64'h8000_0010, 2'b11, 64'hDEAD_BEEF_CAFE_F00D, 2'b00, 5, 3, 0, 0);
      n_checks++; if (tmo !== 0 || lat !== 11) begin n_fail++;
         $display("FAIL wait_latency got=%0d tmo=%0d exp=11", lat, tmo); end
      n_checks++; if (unstable !== 0 || overlap !== 0) begin n_fail++;
         $display("FAIL wait_stable got=unstable%0d overlap%0d exp=0/0", unstable, overlap); end
      n_checks++; if (ar_hs !== 1 || r_hs !== 1 || pulses !== 1) begin n_fail++;
         $display("FAIL wait_counts got=%0d/%0d/%0d exp=1/1/1", ar_hs, r_hs, pulses); end
      n_checks++; if (got_data !== 64'hDEAD_BEEF_CAFE_F00D || got_ar_addr !== 64'h8000_0010) begin n_fail++;
         $display("FAIL wait_data got=%h/%h exp=deadbeefcafef00d/80000010", got_data, got_ar_addr); end
   endtask

   task automatic test_lanes();
      run_fetch(64'h8000_0007, 2'b00, 64'hAB00_0000_0000_0000, 2'b00, 0, 0, 0, 0);
      n_checks++; if (got_data !== 64'h0000_0000_0000_00AB || got_resp !== 2'b00) begin n_fail++;
         $display("FAIL byte7 got=%h/%b exp=ab/00", got_data, got_resp); end
      run_fetch(64'h8000_0007, 2'b01, 64'hCD00_0000_0000_0000, 2'b00, 0, 0, 0, 0);
      n_checks++; if (got_data !== 64'h0000_0000_0000_00CD || got_resp !== 2'b10) begin n_fail++;
         $display("FAIL half7_misalign got=%h/%b exp=cd/10", got_data, got_resp); end
      n_checks++; if (got_ar_addr !== 64'h8000_0000 || got_ar_size !== 3'b001 || ar_hs !== 1) begin n_fail++;
         $display("FAIL half7_ar got=%h/%b/%0d exp=80000000/001/1", got_ar_addr, got_ar_size, ar_hs); end
      run_fetch(64'h8000_0004, 2'b11, 64'h1122_3344_5566_7788, 2'b00, 0, 0, 0, 0);
      n_checks++; if (got_data !== 64'h0000_0000_1122_3344 || got_resp !== 2'b10) begin n_fail++;
         $display("FAIL dword4_misalign got=%h/%b exp=11223344/10", got_data, got_resp); end
      run_fetch(64'h0000_0106, 2'b01, 64'h1234_5678_9ABC_DEF0, 2'b00, 0, 0, 0, 0);
      n_checks++; if (got_data !== 64'h0000_0000_0000_1234 || got_resp !== 2'b00) begin n_fail++;
         $display("FAIL half6 got=%h/%b exp=1234/00", got_data, got_resp); end
   endtask

   task automatic test_resp_id();
      run_fetch(64'h8000_0008, 2'b11, 64'h0123_4567_89AB_CDEF, 2'b11, 0, 0, 1, 0);
      n_checks++; if (got_resp !== 2'b11 || got_data !== 64'h0123_4567_89AB_CDEF) begin n_fail++;
         $display("FAIL decerr_id got=%h/%b exp=0123456789abcdef/11", got_data, got_resp); end
      n_checks++; if (tmo !== 0 || lat !== 4 || pulses !== 1) begin n_fail++;
         $display("FAIL bad_id_skip got=lat%0d pulses%0d exp=4/1", lat, pulses); end
   endtask

   task automatic test_back_to_back();
      run_fetch(64'h0000_0100, 2'b00, 64'h0000_0000_0000_005A, 2'b00, 0, 0, 0, 1);
      n_checks++; if (got_data !== 64'h5A || lat !== 3) begin n_fail++;
         $display("FAIL b2b_first got=%h lat%0d exp=5a/3", got_data, lat); end
      run_fetch(64'h0000_0102, 2'b01, 64'h0000_0000_BEEF_0000, 2'b01, 0, 0, 0, 0);
      n_checks++; if (got_data !== 64'hBEEF || got_resp !== 2'b01 || lat !== 4) begin n_fail++;
         $display("FAIL b2b_second got=%h/%b lat%0d exp=beef/01/4", got_data, got_resp, lat); end
   endtask

   task automatic test_reset_mid();
      bit in_r = 0;
      if_valid = 1'b1; if_addr = 64'h8000_0020; if_size = 2'b11;
      for (int c = 0; c < 20 && !in_r; c++) begin
         @(posedge clock); @(negedge clock);
         ar_ready = ar_valid;
         if (r_ready) in_r = 1;
      end
      n_checks++; if (in_r !== 1) begin n_fail++;
         $display("FAIL mid_reach_r got=%0d exp=1", in_r); end
      ar_ready = 1'b0; reset = 1'b1; if_valid = 1'b0;
      @(posedge clock); @(negedge clock);
      n_checks++; if ({ar_valid, r_ready, if_ready} !== 3'b000 || dbg_state !== 3'd0) begin n_fail++;
         $display("FAIL mid_reset got=%b/%0d exp=000/0", {ar_valid, r_ready, if_ready}, dbg_state); end
      reset = 1'b0;
      run_fetch(64'h8000_0003, 2'b00, 64'h0000_0000_7700_0000, 2'b00, 0, 0, 0, 0);
      n_checks++; if (got_data !== 64'h77 || got_resp !== 2'b00 || lat !== 3) begin n_fail++;
         $display("FAIL after_reset got=%h/%b lat%0d exp=77/00/3", got_data, got_resp, lat); end
   endtask

`ifdef IF_AXI_RD_BRIDGE_TIMEOUT_EN
   task automatic test_timeout();
      run_fetch(64'h8000_0040, 2'b11, 64'h1111_2222_3333_4444, 2'b00, 0, 100, 0, 0);
      n_checks++; if (tmo !== 0 || lat !== 17) begin n_fail++;
         $display("FAIL to_latency got=%0d tmo=%0d exp=17", lat, tmo); end
      n_checks++; if (got_data !== 64'd0 || got_resp !== 2'b11) begin n_fail++;
         $display("FAIL to_result got=%h/%b exp=0/11", got_data, got_resp); end
      if_valid = 1'b1; if_addr = 64'h8000_0048;
      repeat (2) begin @(posedge clock); @(negedge clock); end
      n_checks++; if (dbg_state !== 3'd4 || r_ready !== 1'b1 || ar_valid !== 1'b0) begin n_fail++;
         $display("FAIL to_drain got=%0d/%b/%b exp=4/1/0", dbg_state, r_ready, ar_valid); end
      if_valid = 1'b0; r_valid = 1'b1; r_last = 1'b1; r_id = '0;
      @(posedge clock); @(negedge clock);
      r_valid = 1'b0; r_last = 1'b0;
      n_checks++; if (dbg_state !== 3'd0 || r_ready !== 1'b0) begin n_fail++;
         $display("FAIL to_drained got=%0d/%b exp=0/0", dbg_state, r_ready); end
      run_fetch(64'h8000_0048, 2'b10, 64'h0000_0000_CAFE_BABE, 2'b00, 0, 0, 0, 0);
      n_checks++; if (got_data !== 64'hCAFE_BABE || got_resp !== 2'b00) begin n_fail++;
         $display("FAIL to_recover got=%h/%b exp=cafebabe/00", got_data, got_resp); end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_waits();
      test_lanes();
      test_resp_id();
      test_back_to_back();
      test_reset_mid();
`ifdef IF_AXI_RD_BRIDGE_TIMEOUT_EN
      test_timeout();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
